// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts fetch PCs, returns store words in order after a fixed
// latency through a credit-limited response FIFO; includes a program load port.
module imem_responder #(
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [31:0]                   req_addr,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [31:0]                   resp_data,
  output logic                          resp_err,
  input  logic                          flush,
  input  logic                          load_we,
  input  logic [$clog2(DEPTH)-1:0]      load_addr,
  input  logic [31:0]                   load_data,
  output logic [$clog2(FIFO_DEPTH):0]   outstanding
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = $clog2(FIFO_DEPTH);
  localparam int unsigned PS = (LATENCY > 1) ? LATENCY - 1 : 1;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } resp_t;

  logic [31:0]        mem [DEPTH];
  logic [PS-1:0]      pipe_v;
  resp_t              pipe_r [PS];
  logic [LATENCY-1:0] stage_v;
  resp_t              stage_r [LATENCY];
  resp_t              fifo_q [FIFO_DEPTH];
  logic [FW-1:0]      wptr_q, rptr_q;
  logic [FW:0]        fcnt_q, cnt_q;

  logic        fire, pop, push, in_err;
  resp_t       push_r;
  logic [AW-1:0] word_idx;

  assign word_idx = req_addr[AW+1:2];
  assign in_err   = (req_addr[1:0] != 2'b00) | (|req_addr[31:AW+2]);

  // cnt_q covers both pipe and FIFO, so the pipe can never overflow the FIFO
  assign req_ready = rst & ~flush & (cnt_q < (FW+1)'(FIFO_DEPTH));
  assign fire      = req_valid & req_ready;

  assign resp_valid  = (fcnt_q != '0);
  assign resp_data   = resp_valid ? fifo_q[rptr_q].data : '0;
  assign resp_err    = resp_valid ? fifo_q[rptr_q].err  : 1'b0;
  assign outstanding = cnt_q;
  assign pop         = resp_valid & resp_ready;

  // Stage 0 is the combinational store read at the acceptance edge; the last stage feeds the FIFO
  always_comb begin
    stage_v[0]      = fire;
    stage_r[0].err  = in_err;
    stage_r[0].data = in_err ? NOP_WORD : mem[word_idx];
    for (int unsigned i = 1; i < LATENCY; i++) begin
      stage_v[i] = pipe_v[i-1];
      stage_r[i] = pipe_r[i-1];
    end
  end

  assign push   = stage_v[LATENCY-1];
  assign push_r = stage_r[LATENCY-1];

  always_ff @(posedge clk) begin
    if (load_we) mem[load_addr] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (rst && !flush && push) fifo_q[wptr_q] <= push_r;
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      pipe_v <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      fcnt_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int unsigned i = 0; i + 1 < LATENCY; i++) begin
        pipe_v[i] <= stage_v[i];
        pipe_r[i] <= stage_r[i];
      end
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      fcnt_q <= fcnt_q + (FW+1)'(push) - (FW+1)'(pop);
      cnt_q  <= cnt_q  + (FW+1)'(fire) - (FW+1)'(pop);
    end
  end

endmodule
